alu_accum_unit: RTL and testbench

ALU_ACCUM_UNIT -- requirements
Module: alu_accum_unit

---
 rtl/alu_accum_unit.sv | 172 +++++++++++++++++
 tb/tb_alu_accum_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_unit.sv
// Accumulator ALU: single-cycle arithmetic/logic ops on an accumulator plus an
// optional sequential shift-add multiplier.
module alu_accum_unit #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] arg,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic [4:0]       flags
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_acc, w_acc_next;
  logic [4:0]         r_flags, w_flags_next;
  logic               r_done, w_done_next;
  logic               w_mul_start, w_mul_last;
  logic [2*WIDTH-1:0] w_prod_sum;
  logic [WIDTH:0]     w_add, w_sub;

  // Flags packed as {P, V, N, Z, C}; P set on an even count of ones.
  function automatic logic [4:0] pack_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
    return {~^res, v, res[WIDTH-1], (res == '0), c};
  endfunction

  // The carry flag doubles as carry-in for ADD and borrow-in for SUB.
  assign w_add = {1'b0, r_acc} + {1'b0, arg} + {{WIDTH{1'b0}}, r_flags[0]};
  assign w_sub = {1'b0, r_acc} - {1'b0, arg} - {{WIDTH{1'b0}}, r_flags[0]};

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_flags_next = r_flags;
    w_done_next  = 1'b0;
    w_mul_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_done_next = 1'b1;
          case (opcode)
            4'd0: begin
              w_acc_next   = w_add[WIDTH-1:0];
              w_flags_next = pack_flags(w_add[WIDTH-1:0], w_add[WIDTH],
                               (r_acc[WIDTH-1] == arg[WIDTH-1]) &&
                               (w_add[WIDTH-1] != r_acc[WIDTH-1]));
            end
            4'd1: begin
              w_acc_next   = w_sub[WIDTH-1:0];
              w_flags_next = pack_flags(w_sub[WIDTH-1:0], w_sub[WIDTH],
                               (r_acc[WIDTH-1] != arg[WIDTH-1]) &&
                               (w_sub[WIDTH-1] != r_acc[WIDTH-1]));
            end
            4'd2: begin
              w_acc_next   = r_acc & arg;
              w_flags_next = pack_flags(r_acc & arg, 1'b0, 1'b0);
            end
            4'd3: begin
              w_acc_next   = r_acc | arg;
              w_flags_next = pack_flags(r_acc | arg, 1'b0, 1'b0);
            end
            4'd4: begin
              w_acc_next   = r_acc ^ arg;
              w_flags_next = pack_flags(r_acc ^ arg, 1'b0, 1'b0);
            end
            4'd5: begin
              w_acc_next   = ~r_acc;
              w_flags_next = pack_flags(~r_acc, 1'b0, 1'b0);
            end
            4'd6: begin
              w_acc_next   = {r_acc[WIDTH-2:0], 1'b0};
              w_flags_next = pack_flags({r_acc[WIDTH-2:0], 1'b0}, r_acc[WIDTH-1], 1'b0);
            end
            4'd7: begin
              w_acc_next   = {1'b0, r_acc[WIDTH-1:1]};
              w_flags_next = pack_flags({1'b0, r_acc[WIDTH-1:1]}, r_acc[0], 1'b0);
            end
            4'd8: begin
              w_acc_next   = arg;
              w_flags_next = pack_flags(arg, 1'b0, 1'b0);
            end
            4'd9: begin
              if (MUL_EN != 0) begin
                w_done_next  = 1'b0;
                w_mul_start  = 1'b1;
                w_state_next = S_MUL;
              end
            end
            4'd10: w_flags_next = '0;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_state_next = S_IDLE;
          w_acc_next   = w_prod_sum[WIDTH-1:0];
          w_flags_next = pack_flags(w_prod_sum[WIDTH-1:0],
                                    |w_prod_sum[2*WIDTH-1:WIDTH], 1'b0);
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_acc   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_acc   <= w_acc_next;
      r_flags <= w_flags_next;
      r_done  <= w_done_next;
    end
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      logic [2*WIDTH-1:0] r_mcand, r_prod;
      logic [WIDTH-1:0]   r_mplier;
      logic [CNT_W-1:0]   r_cnt;

      // Product term for this cycle; the last one is written straight to acc.
      assign w_prod_sum = r_prod + (r_mplier[0] ? r_mcand : '0);
      assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_mcand  <= '0;
          r_prod   <= '0;
          r_mplier <= '0;
          r_cnt    <= '0;
        end else if (w_mul_start) begin
          r_mcand  <= {{WIDTH{1'b0}}, r_acc};
          r_prod   <= '0;
          r_mplier <= arg;
          r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
          r_prod   <= w_prod_sum;
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
        end
      end
    end else begin : g_no_mul
      assign w_prod_sum = '0;
      assign w_mul_last = 1'b0;
    end
  endgenerate

  assign busy  = (r_state == S_MUL);
  assign done  = r_done;
  assign acc   = r_acc;
  assign flags = r_flags;

endmodule

// File: tb/tb_alu_accum_unit.sv
// Self-checking bench for alu_accum_unit (WIDTH=16): directed sequences with
// literal expectations, then randomized traffic against a behavioural model.
module tb_alu_accum_unit;

  localparam int    W = 16;
  localparam longint M = longint'(1) << W;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    opcode = '0;
  logic [W-1:0]  arg = '0;
  logic          busy, done;
  logic [W-1:0]  acc;
  logic [4:0]    flags;

  alu_accum_unit #(.WIDTH(W), .MUL_EN(1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .opcode(opcode), .arg(arg),
    .busy(busy), .done(done), .acc(acc), .flags(flags)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  longint   m_acc  = 0;
  logic [4:0] m_flags = '0;
  bit       m_done = 0;
  int       m_left = 0;
  longint   m_prod = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] mk(input longint r, input bit c, input bit v);
    logic [W-1:0] r16;
    r16 = r[W-1:0];
    return {($countones(r16) % 2) == 0, v, r16[W-1], r16 == 0, c};
  endfunction

  function automatic longint sgn(input longint x);
    return (x >= M/2) ? x - M : x;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_flags = '0; m_done = 0; m_left = 0; m_prod = 0;
  endtask

  task automatic model_edge(input bit st, input logic [3:0] op, input logic [W-1:0] a);
    longint r, ss;
    bit c, v;
    m_done = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_acc   = m_prod % M;
        m_flags = mk(m_acc, (m_prod / M) != 0, 0);
        m_done  = 1;
      end
    end else if (st) begin
      m_done = 1;
      c = m_flags[0];
      case (op)
        4'd0: begin
          r  = m_acc + a + c;
          ss = sgn(m_acc) + sgn(a) + c;
          v  = (ss >= M/2) || (ss < -M/2);
          m_flags = mk(r % M, r >= M, v);
          m_acc = r % M;
        end
        4'd1: begin
          r  = m_acc - a - c;
          ss = sgn(m_acc) - sgn(a) - c;
          v  = (ss >= M/2) || (ss < -M/2);
          m_flags = mk((r < 0) ? r + M : r, r < 0, v);
          m_acc = (r < 0) ? r + M : r;
        end
        4'd2: begin m_acc = m_acc & a;       m_flags = mk(m_acc, 0, 0); end
        4'd3: begin m_acc = m_acc | a;       m_flags = mk(m_acc, 0, 0); end
        4'd4: begin m_acc = m_acc ^ a;       m_flags = mk(m_acc, 0, 0); end
        4'd5: begin m_acc = (M - 1) - m_acc; m_flags = mk(m_acc, 0, 0); end
        4'd6: begin
          c = (m_acc >= M/2);
          m_acc = (m_acc * 2) % M;
          m_flags = mk(m_acc, c, 0);
        end
        4'd7: begin
          c = (m_acc % 2) == 1;
          m_acc = m_acc / 2;
          m_flags = mk(m_acc, c, 0);
        end
        4'd8: begin m_acc = a; m_flags = mk(m_acc, 0, 0); end
        4'd9: begin m_prod = m_acc * a; m_left = W; m_done = 0; end
        4'd10: m_flags = '0;
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit st, input logic [3:0] op, input logic [W-1:0] a);
    start = st; opcode = op; arg = a;
    @(posedge CLK);
    model_edge(st, op, a);
    @(negedge CLK);
    start = 1'b0;
    chk("acc", 32'(acc), 32'(m_acc[W-1:0]));
    chk("flags", 32'(flags), 32'(m_flags));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    $display("t=%0t st=%0d op=%0d arg=%0d -> acc=%0d flags=%05b busy=%0d done=%0d",
             $time, st, op, a, acc, flags, busy, done);
  endtask

  int busy_cnt, done_cnt;

  initial begin
    // Power-on reset
    #1 RST = 1'b1;
    #1;
    chk("rst_acc", 32'(acc), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;

    // ADD chain with carry-in
    cycle(1, 0, 20000);
    chk("add1_acc", 32'(acc), 20000);
    chk("add1_flags", 32'(flags), 32'b00000);
    cycle(1, 0, 20000);
    chk("add2_acc", 32'(acc), 40000);
    chk("add2_flags", 32'(flags), 32'b01100);
    cycle(1, 0, 40000);
    chk("add3_acc", 32'(acc), 14464);
    chk("add3_c", 32'(flags[0]), 1);
    cycle(1, 0, 0);
    chk("add4_acc", 32'(acc), 14465);
    chk("add4_c", 32'(flags[0]), 0);

    // SUB with borrow
    cycle(1, 8, 5);
    cycle(1, 1, 7);
    chk("sub1_acc", 32'(acc), 65534);
    chk("sub1_czn", 32'({flags[2], flags[1], flags[0]}), 32'b101);
    cycle(1, 1, 0);
    chk("sub2_acc", 32'(acc), 65533);
    chk("sub2_c", 32'(flags[0]), 0);

    // MUL, with a start issued mid-operation that must be ignored
    cycle(1, 8, 300);
    cycle(1, 9, 300);
    busy_cnt = int'(busy);
    done_cnt = 0;
    for (int i = 1; i <= 17; i++) begin
      cycle(i == 7, 0, 1);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    chk("mul_acc", 32'(acc), 24464);
    chk("mul_c", 32'(flags[0]), 1);
    chk("mul_busy_cycles", 32'(busy_cnt), 16);
    chk("mul_done_pulses", 32'(done_cnt), 1);

    // Zero / parity / CLRF / SHL / NOP
    cycle(1, 8, 0);
    chk("load0_flags", 32'(flags), 32'b10010);
    cycle(1, 10, 16'h1234);
    chk("clrf_flags", 32'(flags), 0);
    chk("clrf_acc", 32'(acc), 0);
    cycle(1, 8, 16'h8001);
    cycle(1, 6, 0);
    chk("shl_acc", 32'(acc), 2);
    chk("shl_flags", 32'(flags), 32'b00001);
    cycle(1, 12, 16'hBEEF);
    chk("nop_done", 32'(done), 1);
    chk("nop_acc", 32'(acc), 2);
    chk("nop_flags", 32'(flags), 32'b00001);

    // Back-to-back: MUL then an op accepted in the cycle done is high
    cycle(1, 8, 3);
    cycle(1, 9, 7);
    for (int i = 1; i <= 15; i++) cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 8, 99);
    chk("b2b_acc", 32'(acc), 99);

    // Reset in the middle of a MUL
    cycle(1, 8, 300);
    cycle(1, 9, 300);
    for (int i = 1; i <= 5; i++) cycle(0, 0, 0);
    #2 RST = 1'b1;
    #1;
    chk("abort_acc", 32'(acc), 0);
    chk("abort_flags", 32'(flags), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0);
      done_cnt += int'(done);
    end
    chk("abort_no_done", 32'(done_cnt), 0);
    cycle(1, 0, 1);
    chk("post_abort_acc", 32'(acc), 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] a;
      case ($urandom % 6)
        0: a = 16'h0000;
        1: a = 16'hFFFF;
        2: a = 16'h8000;
        3: a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      cycle(($urandom % 3) != 0, 4'($urandom % 16), a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
